ps2_device: RTL and testbench



---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_line_sync.sv | 39 +++
 rtl/ps2_device.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_ps2_device.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types, constants and helpers for the PS/2 device
//                endpoint (FSM state encoding, frame length, keyboard reply
//                codes, odd-parity helper).
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_WAIT = 3'd1,
    ST_TX_HI   = 3'd2,
    ST_TX_LO   = 3'd3,
    ST_RX_HI   = 3'd4,
    ST_RX_LO   = 3'd5,
    ST_RX_ACK  = 3'd6,
    ST_RECOVER = 3'd7
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_RESET_CMD = 8'hFF;

  // Cycles after releasing the clock line before the synchronized level can
  // reflect the release; inhibit sensing is masked for this long.
  localparam logic [15:0] SYNC_SKIP = 16'd2;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_sync
//  Description : Two-flop synchronizer for the PS/2 clock and data lines.
//                Flops reset to 1 (idle, released bus level).
//  Ports       : clk, rst_n     system clock / async active-low reset
//                ps2_clk_i      raw PS/2 clock line level
//                ps2_dat_i      raw PS/2 data line level
//                clk_s_o        synchronized clock line level
//                dat_s_o        synchronized data line level
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_s_o,
  output logic dat_s_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] dat_ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ff_q <= 2'b11;
      dat_ff_q <= 2'b11;
    end else begin
      clk_ff_q <= {clk_ff_q[0], ps2_clk_i};
      dat_ff_q <= {dat_ff_q[0], ps2_dat_i};
    end
  end

  assign clk_s_o = clk_ff_q[1];
  assign dat_s_o = dat_ff_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_device.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_device
//  Description : PS/2 device-side (keyboard) endpoint. Generates the PS/2
//                clock, sends bytes to the host and receives host command
//                bytes, driving the ack bit.
//  Ports       : clk, rst_n           system clock / async active-low reset
//                tx_data/tx_valid     byte to send; accepted when tx_ready
//                tx_ready             holding register empty
//                tx_done / tx_abort   1-cycle pulses: frame sent / inhibited
//                rx_data              last good host byte
//                rx_valid / rx_err    1-cycle pulses: good byte / bad frame
//                busy                 FSM not idle
//                ps2_clk_i/ps2_dat_i  PS/2 line levels
//                ps2_clk_oe/_dat_oe   1 = pull the line low
//  Options     : PS2_DEVICE_AUTO_REPLY_EN -- answer host bytes internally
//                (0xFA ack, 0xAA after 0xFF, 0xFE on parity error).
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_device #(
  parameter int CLK_FREQ = 10,
  parameter int HALF_US  = 40,
  parameter int IDLE_US  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  import ps2_pkg::*;

  localparam logic [15:0] HALF_CYC  = 16'(CLK_FREQ * HALF_US);
  localparam logic [15:0] HALF_LAST = 16'(CLK_FREQ * HALF_US - 1);
  localparam logic [15:0] ACK_LAST  = 16'(2 * CLK_FREQ * HALF_US - 1);
  localparam logic [15:0] IDLE_LAST = 16'(CLK_FREQ * IDLE_US - 1);
  // Trailing high half after the 11th clock; inhibit is ignored there.
  localparam logic [3:0]  TX_TAIL   = 4'(FRAME_BITS);
  localparam logic [3:0]  RX_STOP   = 4'(FRAME_BITS - 1);

  logic clk_s, dat_s;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .clk_s_o   (clk_s),
    .dat_s_o   (dat_s)
  );

  ps2_state_e  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  bit_q, bit_d;
  logic [10:0] tx_sh_q, tx_sh_d;
  logic [9:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        clk_oe_q, clk_oe_d;
  logic        dat_oe_q, dat_oe_d;
  logic        tx_done_q, tx_abort_q, rx_valid_q, rx_err_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;

  logic        frame_done, frame_abort;
  logic        rx_good, rx_bad_par, rx_bad_stop;
  logic        reply_pend;
  logic [7:0]  reply_byte;
  logic        from_reply;
  logic        pending;
  logic [7:0]  next_byte;
  logic        rts;

  // Host request-to-send: clock released, data held low.
  assign rts       = clk_s & ~dat_s;
  assign pending   = hold_full_q | reply_pend;
  assign next_byte = reply_pend ? reply_byte : hold_q;

  // --------------------------------------------------------------------------
  // Auto-reply queue (2 entries, priority over the holding register)
  // --------------------------------------------------------------------------
`ifdef PS2_DEVICE_AUTO_REPLY_EN
  logic [7:0] aq0_q, aq1_q;
  logic [1:0] aq_cnt_q;
  logic       tx_from_q_q;
  logic [7:0] push_v0, push_v1;
  logic       push_en, push_two;

  always_comb begin
    push_en  = rx_good | rx_bad_par;
    push_two = rx_good & (rx_sh_d[7:0] == PS2_RESET_CMD);
    push_v0  = rx_good ? PS2_ACK : PS2_RESEND;
    push_v1  = PS2_BAT_OK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq0_q       <= '0;
      aq1_q       <= '0;
      aq_cnt_q    <= '0;
      tx_from_q_q <= 1'b0;
    end else begin
      // Source of the frame is latched as it starts so retries after an
      // abort reuse the same byte.
      if (state_q == ST_TX_WAIT && state_d == ST_TX_HI)
        tx_from_q_q <= reply_pend;
      // Push (RX) and pop (TX end) come from disjoint states.
      if (push_en) begin
        if (aq_cnt_q == 2'd0) begin
          aq0_q <= push_v0;
          if (push_two) begin
            aq1_q    <= push_v1;
            aq_cnt_q <= 2'd2;
          end else begin
            aq_cnt_q <= 2'd1;
          end
        end else if (aq_cnt_q == 2'd1) begin
          aq1_q    <= push_v0;
          aq_cnt_q <= 2'd2;
        end
      end else if (frame_done && tx_from_q_q) begin
        aq0_q    <= aq1_q;
        aq_cnt_q <= aq_cnt_q - 2'd1;
      end
    end
  end

  assign reply_pend = (aq_cnt_q != 2'd0);
  assign reply_byte = aq0_q;
  assign from_reply = tx_from_q_q;
`else
  assign reply_pend = 1'b0;
  assign reply_byte = 8'h00;
  assign from_reply = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Holding register
  // --------------------------------------------------------------------------
  assign tx_ready = ~hold_full_q & ~reply_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (frame_done && !from_reply) begin
      hold_full_q <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold_q      <= tx_data;
      hold_full_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 16'd1;
    bit_d       = bit_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    rx_good     = 1'b0;
    rx_bad_par  = 1'b0;
    rx_bad_stop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        bit_d   = '0;
        if (rts)          state_d = ST_RX_HI;
        else if (pending) state_d = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        // A host RTS arriving while we wait for idle still wins; otherwise
        // the host would wait for clocks that never come.
        if (rts) begin
          state_d = ST_RX_HI;
          timer_d = '0;
          bit_d   = '0;
        end else if (!clk_s || !dat_s) begin
          timer_d = '0;
        end else if (timer_q == IDLE_LAST) begin
          state_d = ST_TX_HI;
          timer_d = '0;
          bit_d   = '0;
          tx_sh_d = {1'b1, odd_parity(next_byte), next_byte, 1'b0};
        end
      end

      ST_TX_HI: begin
        if (bit_q != TX_TAIL && timer_q >= SYNC_SKIP && !clk_s && !clk_oe_q) begin
          state_d     = ST_RECOVER;
          timer_d     = '0;
          frame_abort = 1'b1;
        end else if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (bit_q == TX_TAIL) begin
            state_d    = ST_IDLE;
            frame_done = 1'b1;
          end else begin
            state_d = ST_TX_LO;
          end
        end
      end

      ST_TX_LO: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          bit_d   = bit_q + 4'd1;
          // Shift in ones so the trailing half leaves data released.
          tx_sh_d = {1'b1, tx_sh_q[10:1]};
          state_d = ST_TX_HI;
        end
      end

      ST_RX_HI: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          // bit_q == 0 is the lead-in high half before the first clock.
          if (bit_q == 4'd0) begin
            state_d = ST_RX_LO;
          end else begin
            rx_sh_d = {dat_s, rx_sh_q[9:1]};
            if (bit_q == RX_STOP) begin
              if (dat_s) begin
                state_d = ST_RX_ACK;
                if (odd_parity(rx_sh_d[7:0]) == rx_sh_d[8]) begin
                  rx_good   = 1'b1;
                  rx_data_d = rx_sh_d[7:0];
                end else begin
                  rx_bad_par = 1'b1;
                end
              end else begin
                state_d     = ST_RECOVER;
                rx_bad_stop = 1'b1;
              end
            end else begin
              state_d = ST_RX_LO;
            end
          end
        end
      end

      ST_RX_LO: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          bit_d   = bit_q + 4'd1;
          state_d = ST_RX_HI;
        end
      end

      ST_RX_ACK: begin
        if (timer_q == ACK_LAST) begin
          timer_d = '0;
          state_d = ST_RECOVER;
        end
      end

      ST_RECOVER: begin
        if (!clk_s) begin
          timer_d = '0;
        end else if (timer_q == IDLE_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Line drivers are registered from the next state so they change in
    // step with the state register.
    clk_oe_d = (state_d == ST_TX_LO) || (state_d == ST_RX_LO) ||
               ((state_d == ST_RX_ACK) && (timer_d < HALF_CYC));
    dat_oe_d = (((state_d == ST_TX_HI) || (state_d == ST_TX_LO)) && !tx_sh_d[0]) ||
               (state_d == ST_RX_ACK);
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '1;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      // Internally generated replies are invisible on the tx_* interface.
      tx_done_q  <= frame_done & ~from_reply;
      tx_abort_q <= frame_abort & ~from_reply;
      rx_valid_q <= rx_good;
      rx_err_q   <= rx_bad_par | rx_bad_stop;
    end
  end

  assign tx_done    = tx_done_q;
  assign tx_abort   = tx_abort_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_err     = rx_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_device.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_device
//  Description : Directed self-checking bench for ps2_device with a simple
//                open-collector host model on the PS/2 lines.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_device;

  localparam int HALF = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_abort, rx_valid, rx_err, busy;
  logic [7:0] rx_data;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       host_clk_pull = 1'b0;
  logic       host_dat_pull = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | host_clk_pull);
  assign dat_line = ~(ps2_dat_oe | host_dat_pull);

  always #5 clk = ~clk;

  ps2_device #(.CLK_FREQ(10), .HALF_US(40), .IDLE_US(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .busy       (busy),
    .ps2_clk_i  (clk_line),
    .ps2_dat_i  (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int checks = 0;
  int failures = 0;

  // Pulse counters and clock-low width monitor (sampled on falling edge).
  int done_cnt = 0, abort_cnt = 0, rxv_cnt = 0, rxe_cnt = 0;
  int lo_run = 0, last_lo = 0;
  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_abort) abort_cnt++;
    if (rx_valid) rxv_cnt++;
    if (rx_err)   rxe_cnt++;
    if (ps2_clk_oe) lo_run++;
    else if (lo_run != 0) begin
      last_lo = lo_run;
      lo_run  = 0;
    end
  end

  // Data line captured at every device-driven clock fall; newest bit at MSB.
  logic [21:0] mon = '0;
  int edges = 0;
  always @(posedge ps2_clk_oe) begin
    mon   = {dat_line, mon[21:1]};
    edges = edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_edges(input int target, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (edges >= target) break;
      @(negedge clk);
    end
    chk(tag, 32'(edges >= target), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Host-to-device frame: RTS, then one bit per device clock fall.
  task automatic host_rx(input logic [7:0] b, input logic flip_par, input logic with_tx);
    logic [9:0] fr;
    int         e0;
    fr = {1'b1, (~(^b)) ^ flip_par, b};
    host_clk_pull = 1'b1;
    repeat (200) @(negedge clk);
    host_dat_pull = 1'b1;
    repeat (20) @(negedge clk);
    if (with_tx) begin
      tx_data  = 8'h1C;
      tx_valid = 1'b1;
    end
    host_clk_pull = 1'b0;
    if (with_tx) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      e0 = edges;
      for (int i = 0; i < 3000; i++) begin
        if (edges != e0) break;
        @(negedge clk);
      end
      if (edges == e0) begin
        checks++;
        failures++;
        $error("FAIL rx_clock_timeout observed=%0d expected=%0d", k, k + 1);
        return;
      end
      host_dat_pull = ~fr[k];
    end
    e0 = edges;
    wait_edges(e0 + 1, 3000, "rx_ack_clock");
    @(negedge clk);
    chk("ack_start", {31'd0, ps2_dat_oe}, 32'd1);
    repeat (HALF + 100) @(negedge clk);
    chk("ack_hold", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
    repeat (HALF) @(negedge clk);
  endtask

  int d0, a0, v0, r0, e0;

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("rst_outs", {28'd0, tx_done, tx_abort, rx_valid, rx_err}, 32'd0);
    chk("rst_busy_rxdata", {23'd0, busy, rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ---------------- plain TX 0x1C ----------------
    d0 = done_cnt; e0 = edges;
    send_byte(8'h1C);
    chk("tx_ready_busy", {31'd0, tx_ready}, 32'd0);
    wait_done(d0 + 1, 12000, "tx1_done_seen");
    @(negedge clk);
    chk("tx1_frame", {21'd0, mon[21:11]}, 32'h438);
    chk("tx1_clocks", edges - e0, 32'd11);
    chk("tx1_low_width", last_lo, HALF);
    chk("tx1_ready_oe", {29'd0, tx_ready, ps2_clk_oe, ps2_dat_oe}, 32'b100);
    chk("tx1_done_once", done_cnt - d0, 32'd1);

    // ---------------- TX with host inhibit at bit 5 ----------------
    repeat (20) @(negedge clk);
    d0 = done_cnt; a0 = abort_cnt; e0 = edges;
    send_byte(8'h1C);
    wait_edges(e0 + 5, 6000, "abort_reach_bit5");
    repeat (500) @(negedge clk);
    host_clk_pull = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_pulse", abort_cnt - a0, 32'd1);
    chk("abort_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("abort_kept", {31'd0, tx_ready}, 32'd0);
    repeat (980) @(negedge clk);
    host_clk_pull = 1'b0;
    wait_done(d0 + 1, 14000, "retry_done_seen");
    @(negedge clk);
    chk("retry_frame", {21'd0, mon[21:11]}, 32'h438);
    chk("retry_abort_once", abort_cnt - a0, 32'd1);
    chk("retry_ready", {31'd0, tx_ready}, 32'd1);

`ifndef PS2_DEVICE_AUTO_REPLY_EN
    // ---------------- RX 0xED good parity ----------------
    repeat (20) @(negedge clk);
    wait_idle(2000);
    v0 = rxv_cnt; r0 = rxe_cnt;
    host_rx(8'hED, 1'b0, 1'b0);
    host_dat_pull = 1'b0;
    chk("rx_good_data", {24'd0, rx_data}, 32'hED);
    chk("rx_good_pulse", rxv_cnt - v0, 32'd1);
    chk("rx_good_noerr", rxe_cnt - r0, 32'd0);

    // ---------------- RX 0xED bad parity ----------------
    wait_idle(2000);
    repeat (20) @(negedge clk);
    v0 = rxv_cnt; r0 = rxe_cnt;
    host_rx(8'hED, 1'b1, 1'b0);
    host_dat_pull = 1'b0;
    chk("rx_bad_err", rxe_cnt - r0, 32'd1);
    chk("rx_bad_novalid", rxv_cnt - v0, 32'd0);

    // ---------------- RTS and tx_valid together ----------------
    wait_idle(2000);
    repeat (20) @(negedge clk);
    v0 = rxv_cnt; d0 = done_cnt;
    host_rx(8'hED, 1'b0, 1'b1);
    host_dat_pull = 1'b0;
    chk("rts_first_rx", rxv_cnt - v0, 32'd1);
    chk("rts_first_nodone", done_cnt - d0, 32'd0);
    wait_done(d0 + 1, 14000, "rts_then_tx_done");
    @(negedge clk);
    chk("rts_then_tx_frame", {21'd0, mon[21:11]}, 32'h438);
`else
    // ---------------- auto reply to 0xFF ----------------
    repeat (20) @(negedge clk);
    wait_idle(2000);
    d0 = done_cnt; v0 = rxv_cnt;
    host_rx(8'hFF, 1'b0, 1'b0);
    host_dat_pull = 1'b0;
    chk("auto_rx_valid", rxv_cnt - v0, 32'd1);
    chk("auto_ready_low", {31'd0, tx_ready}, 32'd0);
    e0 = edges;
    wait_edges(e0 + 22, 25000, "auto_two_frames");
    repeat (HALF + 50) @(negedge clk);
    chk("auto_first_fa", {21'd0, mon[10:0]}, 32'h7F4);
    chk("auto_second_aa", {21'd0, mon[21:11]}, 32'h754);
    chk("auto_no_done", done_cnt - d0, 32'd0);
    chk("auto_ready_back", {31'd0, tx_ready}, 32'd1);
`endif

    // ---------------- reset mid-frame ----------------
    wait_idle(2000);
    repeat (20) @(negedge clk);
    d0 = done_cnt; a0 = abort_cnt; e0 = edges;
    send_byte(8'h1C);
    wait_edges(e0 + 3, 6000, "rst_reach_bit3");
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    chk("rst_mid_nopulse", {16'(done_cnt - d0), 16'(abort_cnt - a0)}, 32'd0);
    chk("rst_mid_idle", {30'd0, busy, tx_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
